// File: rtl/pwr_en_sequencer_if.sv
// Control/status bundle between a power-step controller and pwr_en_sequencer.
// The master drives start/abort/config and the slave returns the enable bus and status.
interface pwr_en_sequencer_if #(
    parameter int NUM_MODULES = 32,
    parameter int DWELL_W     = 32,
    parameter int LVL_W       = 6
);
    logic                   start;
    logic                   abort;
    logic [DWELL_W-1:0]     dwell_cycles;
    logic [LVL_W-1:0]       max_level;
    logic [NUM_MODULES-1:0] pwr_en_out;
    logic [LVL_W-1:0]       level;
    logic                   step_strobe;
    logic                   busy;
    logic                   done;

    modport master (
        output start, abort, dwell_cycles, max_level,
        input  pwr_en_out, level, step_strobe, busy, done
    );

    modport slave (
        input  start, abort, dwell_cycles, max_level,
        output pwr_en_out, level, step_strobe, busy, done
    );
endinterface

// File: rtl/pwr_en_sequencer.sv
// Thermometer-code power-enable ramp 0..M..0 with a programmable per-level dwell.
// Optional macro PWR_SEQ_LOOP_EN: repeat the ramp continuously until abort or reset.
module pwr_en_sequencer #(
    parameter int NUM_MODULES = 32,
    parameter int DWELL_W     = 32,
    parameter int LVL_W       = 6
) (
    input  logic              clk100m,
    input  logic              rstn,
    pwr_en_sequencer_if.slave sif
);
    // state  | meaning
    // S_IDLE | waiting for start; all outputs low
    // S_UP   | ramping level upward 0..M, each level held D cycles
    // S_DOWN | ramping level downward M-1..0
    // S_DONE | single cycle with done high, then back to idle
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [LVL_W-1:0]   MAX_LVL  = LVL_W'(NUM_MODULES);
    localparam logic [LVL_W-1:0]   LVL_ONE  = LVL_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    state_t                 state_q, state_d;
    logic [DWELL_W-1:0]     d_last_q, d_last_d;
    logic [DWELL_W-1:0]     cnt_q, cnt_d;
    logic [LVL_W-1:0]       m_q, m_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [NUM_MODULES-1:0] pwr_en_q, pwr_en_d;
    logic                   strobe_q, strobe_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   dwell_end;
    logic                   seq_end;

    // Storing D-1 keeps D = 2^DWELL_W-1 representable without a wider counter.
    assign dwell_end = (cnt_q == d_last_q);

    always_comb begin
        state_d  = state_q;
        d_last_d = d_last_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        strobe_d = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        seq_end  = 1'b0;
        pwr_en_d = '0;

        if (sif.abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            level_d = '0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    busy_d  = 1'b0;
                    level_d = '0;
                    cnt_d   = '0;
                    if (sif.start) begin
                        state_d  = S_UP;
                        d_last_d = (sif.dwell_cycles == '0) ? '0
                                                            : sif.dwell_cycles - DWELL_ONE;
                        m_d      = (sif.max_level > MAX_LVL) ? MAX_LVL : sif.max_level;
                        strobe_d = 1'b1;
                        busy_d   = 1'b1;
                    end
                end
                S_UP: begin
                    if (dwell_end) begin
                        cnt_d = '0;
                        if (level_q < m_q) begin
                            level_d  = level_q + LVL_ONE;
                            strobe_d = 1'b1;
                        end else if (m_q != '0) begin
                            state_d  = S_DOWN;
                            level_d  = m_q - LVL_ONE;
                            strobe_d = 1'b1;
                        end else begin
                            seq_end = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + DWELL_ONE;
                    end
                end
                S_DOWN: begin
                    if (dwell_end) begin
                        cnt_d = '0;
                        if (level_q != '0) begin
                            level_d  = level_q - LVL_ONE;
                            strobe_d = 1'b1;
                        end else begin
                            seq_end = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + DWELL_ONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    level_d = '0;
                end
            endcase

            if (seq_end) begin
`ifdef PWR_SEQ_LOOP_EN
                // Re-enter UP directly so the final and first level-0 dwells abut.
                state_d  = S_UP;
                level_d  = '0;
                strobe_d = 1'b1;
                busy_d   = 1'b1;
                done_d   = 1'b1;
`else
                state_d  = S_DONE;
                level_d  = '0;
                busy_d   = 1'b0;
                done_d   = 1'b1;
`endif
            end
        end

        for (int k = 0; k < NUM_MODULES; k++) begin
            pwr_en_d[k] = (LVL_W'(k) < level_d);
        end
    end

    always_ff @(posedge clk100m) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            d_last_q <= '0;
            cnt_q    <= '0;
            m_q      <= '0;
            level_q  <= '0;
            pwr_en_q <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            d_last_q <= d_last_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            level_q  <= level_d;
            pwr_en_q <= pwr_en_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sif.pwr_en_out  = pwr_en_q;
    assign sif.level       = level_q;
    assign sif.step_strobe = strobe_q;
    assign sif.busy        = busy_q;
    assign sif.done        = done_q;
endmodule

// File: tb/tb_pwr_en_sequencer.sv
// Directed bench for pwr_en_sequencer: ramp timing, clamping, abort, reset and busy-time inputs.
module tb_pwr_en_sequencer;
    logic clk = 1'b0;
    logic rstn;
    int   n_cmp = 0;
    int   n_err = 0;

    pwr_en_sequencer_if sif ();

    pwr_en_sequencer dut (
        .clk100m (clk),
        .rstn    (rstn),
        .sif     (sif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},   64'(sif.busy),        64'd0);
        chk({tag, ".done"},   64'(sif.done),        64'd0);
        chk({tag, ".level"},  64'(sif.level),       64'd0);
        chk({tag, ".pwr_en"}, 64'(sif.pwr_en_out),  64'd0);
        chk({tag, ".strobe"}, 64'(sif.step_strobe), 64'd0);
    endtask

    // Returns at the negedge of the first busy cycle.
    task automatic start_seq(input logic [31:0] dw, input logic [5:0] mx);
        @(negedge clk);
        sif.dwell_cycles = dw;
        sif.max_level    = mx;
        sif.start        = 1'b1;
        @(negedge clk);
        sif.start        = 1'b0;
    endtask

    // Checks every busy cycle of a 0..m..0 ramp; poke disturbs inputs mid-ramp.
    task automatic expect_ramp(input string tag, input int d, input int m, input bit poke);
        int lv;
        logic [63:0] en;
        for (int i = 0; i < 2*m + 1; i++) begin
            lv = (i <= m) ? i : 2*m - i;
            en = (64'd1 << lv) - 64'd1;
            for (int c = 0; c < d; c++) begin
                chk({tag, ".level"},  64'(sif.level),       64'(lv));
                chk({tag, ".pwr_en"}, 64'(sif.pwr_en_out),  en);
                chk({tag, ".busy"},   64'(sif.busy),        64'd1);
                chk({tag, ".done"},   64'(sif.done),        64'd0);
                chk({tag, ".strobe"}, 64'(sif.step_strobe), 64'(c == 0));
                if (poke && i == 1 && c == 0) begin
                    sif.start        = 1'b1;
                    sif.dwell_cycles = 32'd1;
                    sif.max_level    = 6'd7;
                end else begin
                    sif.start = 1'b0;
                end
                @(negedge clk);
            end
        end
    endtask

    // At the DONE cycle: a held start must be ignored there.
    task automatic expect_done(input string tag);
        chk({tag, ".done_pulse"}, 64'(sif.done),       64'd1);
        chk({tag, ".done_busy"},  64'(sif.busy),       64'd0);
        chk({tag, ".done_level"}, 64'(sif.level),      64'd0);
        chk({tag, ".done_en"},    64'(sif.pwr_en_out), 64'd0);
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        chk_idle({tag, ".after"});
        @(negedge clk);
        chk_idle({tag, ".after2"});
    endtask

    initial begin
        rstn             = 1'b0;
        sif.start        = 1'b0;
        sif.abort        = 1'b0;
        sif.dwell_cycles = '0;
        sif.max_level    = '0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rstn = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

`ifndef PWR_SEQ_LOOP_EN
        // levels 0,1,2,1,0 with 3 cycles each
        start_seq(32'd3, 6'd2);
        expect_ramp("t1", 3, 2, 1'b0);
        expect_done("t1");

        start_seq(32'd0, 6'd0);
        expect_ramp("t2_min", 1, 0, 1'b0);
        expect_done("t2_min");

        start_seq(32'd5, 6'd40);
        expect_ramp("t2_clamp", 5, 32, 1'b0);
        expect_done("t2_clamp");

        // abort in the 6th busy cycle (level 1)
        start_seq(32'd4, 6'd3);
        repeat (5) @(negedge clk);
        chk("t3.pre_abort_level", 64'(sif.level), 64'd1);
        chk("t3.pre_abort_en", 64'(sif.pwr_en_out), 64'h1);
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        chk_idle("t3.abort");
        repeat (3) @(negedge clk);
        chk_idle("t3.abort_late");

        @(negedge clk);
        sif.start = 1'b1;
        sif.abort = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        sif.abort = 1'b0;
        chk_idle("t3.start_abort");
        @(negedge clk);
        chk_idle("t3.start_abort2");

        // abort on the last (only) dwell cycle must suppress done
        start_seq(32'd1, 6'd0);
        chk("t3.last_busy", 64'(sif.busy), 64'd1);
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        chk_idle("t3.abort_last");

        start_seq(32'd2, 6'd3);
        expect_ramp("t4", 2, 3, 1'b1);
        expect_done("t4");

        // reset for one cycle while at level 2
        start_seq(32'd3, 6'd3);
        repeat (6) @(negedge clk);
        chk("t5.pre_rst_level", 64'(sif.level), 64'd2);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk_idle("t5.reset");
        start_seq(32'd2, 6'd2);
        expect_ramp("t5.fresh", 2, 2, 1'b0);
        expect_done("t5.fresh");

        // maximum dwell: level 0 holds without an early step
        start_seq(32'hFFFF_FFFF, 6'd1);
        for (int c = 0; c < 20; c++) begin
            chk("maxd.level", 64'(sif.level), 64'd0);
            chk("maxd.strobe", 64'(sif.step_strobe), 64'(c == 0));
            @(negedge clk);
        end
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        chk_idle("maxd.abort");
`else
        start_seq(32'd2, 6'd1);
        for (int lp = 0; lp < 3; lp++) begin
            for (int c = 0; c < 6; c++) begin
                chk("loop.level",  64'(sif.level),       64'(c / 2 == 1));
                chk("loop.busy",   64'(sif.busy),        64'd1);
                chk("loop.strobe", 64'(sif.step_strobe), 64'(c % 2 == 0));
                chk("loop.done",   64'(sif.done),        64'(lp > 0 && c == 0));
                @(negedge clk);
            end
        end
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        chk_idle("loop.abort");
        @(negedge clk);
        chk_idle("loop.abort2");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
